// File: rtl/pio_cmd_pkg.sv
// Shared types for the HPS PIO command responder: opcodes, FSM states and
// the bit positions of the command and response PIO words.
package pio_cmd_pkg;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_LOAD_ADDR,
    OP_SHIFT,
    OP_WRITE,
    OP_READ,
    OP_READ_NIB,
    OP_CLEAR,
    OP_RSVD
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WR_WAIT,
    ST_RD_WAIT,
    ST_ACK
  } state_e;

  localparam int CMD_TGL_BIT  = 7;
  localparam int CMD_OP_MSB   = 6;
  localparam int CMD_OP_LSB   = 4;
  localparam int CMD_NIB_MSB  = 3;

  localparam int RSP_ACK_BIT  = 7;
  localparam int RSP_ERR_BIT  = 6;
  localparam int RSP_BUSY_BIT = 5;

endpackage

// File: rtl/pio_cmd_responder.sv
// Decodes toggle-strobed nibble commands from the HPS PIO into register-bus
// writes and reads, and reports ack/error/busy/nibble back on the status PIO.
module pio_cmd_responder
  import pio_cmd_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [7:0]        cmd_pio,
  output logic [7:0]        rsp_pio,
  output logic              bus_wr_valid,
  input  logic              bus_wr_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  output logic              bus_rd_req,
  input  logic              bus_rd_valid,
  input  logic [DATA_W-1:0] bus_rd_data
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e              state, state_nxt;
  opcode_e             op;
  logic [7:0]          cmd_q;
  logic [3:0]          nib;
  logic                cmd_tgl;
  logic                ack_tgl;
  logic                err;
  logic                busy;
  logic [3:0]          rsp_nib;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   rdreg;
  logic [CNT_W-1:0]    cnt;
  logic                pending;
  logic                timed_out;
  logic [15:0]         rd_pad;

  assign pending   = cmd_q[CMD_TGL_BIT] != ack_tgl;
  assign timed_out = cnt == CNT_W'(TIMEOUT - 1);
  // Zero padding makes READ_NIB indices beyond DATA_W/4 return 0.
  assign rd_pad    = 16'(rdreg);

  // Write handshake: bus_wr_valid is held with addr/data stable in WR_WAIT and
  // the transfer happens on any clock edge where valid and ready are both high.
  assign bus_wr_valid = state == ST_WR_WAIT;
  assign bus_rd_req   = (state == ST_EXEC) && (op == OP_READ);
  assign bus_addr     = addr;
  assign bus_wr_data  = shreg;

  always_comb begin
    rsp_pio               = '0;
    rsp_pio[RSP_ACK_BIT]  = ack_tgl;
    rsp_pio[RSP_ERR_BIT]  = err;
    rsp_pio[RSP_BUSY_BIT] = busy;
    rsp_pio[3:0]          = rsp_nib;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (pending) state_nxt = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_WRITE: state_nxt = ST_WR_WAIT;
          OP_READ:  state_nxt = ST_RD_WAIT;
          default:  state_nxt = ST_ACK;
        endcase
      end
      ST_WR_WAIT: if (bus_wr_ready || timed_out) state_nxt = ST_ACK;
      ST_RD_WAIT: if (bus_rd_valid || timed_out) state_nxt = ST_ACK;
      ST_ACK:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cmd_q   <= '0;
      op      <= OP_NOP;
      nib     <= '0;
      cmd_tgl <= 1'b0;
      ack_tgl <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      rsp_nib <= '0;
      addr    <= '0;
      shreg   <= '0;
      rdreg   <= '0;
      cnt     <= '0;
    end else begin
      cmd_q <= cmd_pio;
      case (state)
        ST_IDLE: begin
          if (pending) begin
            op      <= opcode_e'(cmd_q[CMD_OP_MSB:CMD_OP_LSB]);
            nib     <= cmd_q[CMD_NIB_MSB:0];
            cmd_tgl <= cmd_q[CMD_TGL_BIT];
            busy    <= 1'b1;
          end
        end
        ST_EXEC: begin
          cnt <= '0;
          case (op)
            OP_LOAD_ADDR: addr    <= ADDR_W'(nib);
            OP_SHIFT:     shreg   <= (shreg << 4) | DATA_W'(nib);
            OP_READ_NIB:  rsp_nib <= rd_pad[{nib[1:0], 2'b00} +: 4];
            OP_CLEAR: begin
              shreg <= '0;
              err   <= 1'b0;
            end
            OP_RSVD:      err     <= 1'b1;
            default: ;
          endcase
        end
        ST_WR_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (!bus_wr_ready && timed_out) err <= 1'b1;
        end
        ST_RD_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (bus_rd_valid)   rdreg <= bus_rd_data;
          else if (timed_out) err   <= 1'b1;
        end
        ST_ACK: begin
          ack_tgl <= cmd_tgl;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_cmd_responder.sv
// Bench for pio_cmd_responder: randomized and directed command sequences
// checked against a command-level model of the register file and bus traffic.
module tb_pio_cmd_responder;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;
  localparam int W       = ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;
  logic reset_reset_n;

  // main DUT (DATA_W = 16)
  logic [7:0]        cmd_pio;
  logic [7:0]        rsp_pio;
  logic              bus_wr_valid;
  logic              bus_wr_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic              bus_rd_req;
  logic              bus_rd_valid;
  logic [DATA_W-1:0] bus_rd_data;

  // narrow DUT (DATA_W = 8)
  logic [7:0] cmd8, rsp8, wr_data8, rd_data8;
  logic [3:0] addr8;
  logic       wr_valid8, wr_ready8, rd_req8, rd_valid8;

  pio_cmd_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .cmd_pio(cmd_pio), .rsp_pio(rsp_pio),
    .bus_wr_valid(bus_wr_valid), .bus_wr_ready(bus_wr_ready), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_rd_req(bus_rd_req), .bus_rd_valid(bus_rd_valid),
    .bus_rd_data(bus_rd_data)
  );

  pio_cmd_responder #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TIMEOUT)) u_dut8 (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .cmd_pio(cmd8), .rsp_pio(rsp8),
    .bus_wr_valid(wr_valid8), .bus_wr_ready(wr_ready8), .bus_addr(addr8),
    .bus_wr_data(wr_data8), .bus_rd_req(rd_req8), .bus_rd_valid(rd_valid8),
    .bus_rd_data(rd_data8)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  // command-level reference model
  logic        m_tgl;
  logic        m_err;
  logic [3:0]  m_nib;
  logic [3:0]  m_addr;
  logic [15:0] m_sh;
  logic [15:0] m_rd;
  logic        t8;

  // bus responder knobs
  int          wr_lat;
  bit          wr_hang;
  int          wr_seen;
  int          rd_lat;
  int          rd_pend;
  int          rd_req_cycles;
  logic [15:0] rd_val;
  logic        rd_req8_d;

  // write target: raises ready wr_lat cycles after valid first appears
  always @(negedge clk_clk) begin
    if (bus_wr_valid) begin
      if (!wr_hang && wr_seen >= wr_lat) begin
        bus_wr_ready = 1'b1;
        got_q.push_back({bus_addr, bus_wr_data});
      end else begin
        bus_wr_ready = 1'b0;
      end
      wr_seen++;
    end else begin
      bus_wr_ready = 1'b0;
      wr_seen      = 0;
    end
  end

  // read target: returns rd_val rd_lat cycles after the request pulse
  always @(negedge clk_clk) begin
    bus_rd_valid = 1'b0;
    if (rd_pend > 0) begin
      rd_pend--;
      if (rd_pend == 0) begin
        bus_rd_valid = 1'b1;
        bus_rd_data  = rd_val;
      end
    end
    if (bus_rd_req) begin
      rd_pend = rd_lat;
      rd_req_cycles++;
    end
    rd_valid8 = rd_req8_d;
    rd_req8_d = rd_req8;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  task automatic model_cmd(input logic [2:0] op, input logic [3:0] nib, input bit bus_ok);
    int idx;
    case (op)
      3'd1: m_addr = nib;
      3'd2: m_sh = {m_sh[11:0], nib};
      3'd3: if (bus_ok) exp_q.push_back({m_addr, m_sh}); else m_err = 1'b1;
      3'd4: if (bus_ok) m_rd = rd_val; else m_err = 1'b1;
      3'd5: begin
        idx   = int'(nib[1:0]);
        m_nib = (idx < DATA_W / 4) ? 4'((m_rd >> (4 * idx)) & 16'hF) : 4'h0;
      end
      3'd6: begin m_sh = '0; m_err = 1'b0; end
      3'd7: m_err = 1'b1;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_tgl = 1'b0; m_err = 1'b0; m_nib = '0; m_addr = '0; m_sh = '0; m_rd = '0; t8 = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; returns cycles until the ack toggle shows up.
  task automatic send_cmd(input logic [2:0] op, input logic [3:0] nib,
                          output int lat, output int vcyc, output int busy_bad);
    m_tgl   = ~m_tgl;
    cmd_pio = {m_tgl, op, nib};
    lat = 0; vcyc = 0; busy_bad = 0;
    do begin
      @(negedge clk_clk);
      lat++;
      if (bus_wr_valid) begin
        vcyc++;
        if (rsp_pio[5] !== 1'b1) busy_bad++;
      end
    end while (rsp_pio[7] !== m_tgl && lat < 200);
  endtask

  task automatic send8(input logic [2:0] op, input logic [3:0] nib, output int lat);
    t8   = ~t8;
    cmd8 = {t8, op, nib};
    lat  = 0;
    do begin
      @(negedge clk_clk);
      lat++;
    end while (rsp8[7] !== t8 && lat < 200);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad;
    reset_reset_n = 1'b0;
    cmd_pio = 8'h00; cmd8 = 8'h00; wr_ready8 = 1'b1; rd_data8 = 8'h5A;
    bus_wr_ready = 1'b0; bus_rd_valid = 1'b0; bus_rd_data = '0;
    wr_lat = 0; wr_hang = 0; wr_seen = 0; rd_lat = 1; rd_pend = 0; rd_val = '0;
    rd_req_cycles = 0; rd_req8_d = 1'b0; rd_valid8 = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_clk);
    checks++;
    if (rsp_pio !== 8'h00) begin
      errors++;
      $display("FAIL reset_rsp: got %h, expected 00", rsp_pio);
    end
    checks++;
    if ({bus_wr_valid, bus_rd_req, bus_addr, bus_wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got %b %b %h %h, expected zeros", bus_wr_valid, bus_rd_req, bus_addr, bus_wr_data);
    end
    checks++;
    if ({rsp8, wr_valid8, rd_req8, addr8, wr_data8} !== '0) begin
      errors++;
      $display("FAIL reset_dut8: got %h %b %b %h %h, expected zeros", rsp8, wr_valid8, rd_req8, addr8, wr_data8);
    end
    reset_reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_clk);
      if (rsp_pio !== 8'h00 || bus_wr_valid !== 1'b0 || bus_rd_req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_write_seq();
    logic [2:0] ops[6]  = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
    logic [3:0] nibs[6] = '{4'h5, 4'hA, 4'hB, 4'hC, 4'hD, 4'h0};
    int lat, vcyc, bb;
    logic [W-1:0] g, e;
    wr_lat = 3; wr_hang = 0;
    for (int i = 0; i < 6; i++) begin
      send_cmd(ops[i], nibs[i], lat, vcyc, bb);
      model_cmd(ops[i], nibs[i], 1'b1);
      checks++;
      if (lat != ((ops[i] == 3'd3) ? 4 + wr_lat + 1 : 4)) begin
        errors++;
        $display("FAIL wr_seq_lat[%0d]: got %0d cycles", i, lat);
      end
      checks++;
      if (rsp_pio !== {m_tgl, m_err, 2'b00, m_nib}) begin
        errors++;
        $display("FAIL wr_seq_rsp[%0d]: got %h, expected %h", i, rsp_pio, {m_tgl, m_err, 2'b00, m_nib});
      end
    end
    checks++;
    if (vcyc != 4) begin
      errors++;
      $display("FAIL wr_valid_len: got %0d, expected 4", vcyc);
    end
    checks++;
    if (bb != 0) begin
      errors++;
      $display("FAIL wr_busy: got %0d cycles without busy, expected 0", bb);
    end
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL wr_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e || e !== 20'h5ABCD) begin
        errors++;
        $display("FAIL wr_data: got %h, expected %h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_read_seq();
    int lat, vcyc, bb;
    rd_lat = 2; rd_val = 16'h1234; rd_req_cycles = 0;
    send_cmd(3'd4, 4'h0, lat, vcyc, bb);
    model_cmd(3'd4, 4'h0, 1'b1);
    checks++;
    if (lat != 4 + rd_lat) begin
      errors++;
      $display("FAIL rd_lat: got %0d, expected %0d", lat, 4 + rd_lat);
    end
    checks++;
    if (rd_req_cycles != 1) begin
      errors++;
      $display("FAIL rd_req_pulse: got %0d cycles, expected 1", rd_req_cycles);
    end
    for (int i = 0; i < 4; i++) begin
      send_cmd(3'd5, 4'(i), lat, vcyc, bb);
      model_cmd(3'd5, 4'(i), 1'b1);
      checks++;
      if (rsp_pio !== {m_tgl, m_err, 2'b00, m_nib}) begin
        errors++;
        $display("FAIL rd_nib[%0d]: got %h, expected %h", i, rsp_pio, {m_tgl, m_err, 2'b00, m_nib});
      end
    end
  endtask

  task automatic test_narrow();
    logic [3:0] exp_n[3] = '{4'h0, 4'h5, 4'hA};
    logic [3:0] idx_n[3] = '{4'h3, 4'h1, 4'h0};
    int lat;
    send8(3'd4, 4'h0, lat);
    checks++;
    if (lat >= 200) begin
      errors++;
      $display("FAIL n8_read: got no ack within %0d cycles", lat);
    end
    for (int i = 0; i < 3; i++) begin
      send8(3'd5, idx_n[i], lat);
      checks++;
      if (rsp8[3:0] !== exp_n[i] || rsp8[7] !== t8) begin
        errors++;
        $display("FAIL n8_nib[%0d]: got %h, expected nibble %h", i, rsp8, exp_n[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int lat, vcyc, bb;
    wr_hang = 1;
    send_cmd(3'd3, 4'h0, lat, vcyc, bb);
    model_cmd(3'd3, 4'h0, 1'b0);
    checks++;
    if (vcyc != TIMEOUT) begin
      errors++;
      $display("FAIL to_valid_len: got %0d, expected %0d", vcyc, TIMEOUT);
    end
    checks++;
    if (lat != 4 + TIMEOUT) begin
      errors++;
      $display("FAIL to_lat: got %0d, expected %0d", lat, 4 + TIMEOUT);
    end
    checks++;
    if (rsp_pio !== {m_tgl, m_err, 2'b00, m_nib} || rsp_pio[6] !== 1'b1) begin
      errors++;
      $display("FAIL to_rsp: got %h, expected %h", rsp_pio, {m_tgl, m_err, 2'b00, m_nib});
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL to_nowrite: got %0d writes, expected 0", got_q.size());
    end
    wr_hang = 0;
    send_cmd(3'd6, 4'h0, lat, vcyc, bb);
    model_cmd(3'd6, 4'h0, 1'b1);
    checks++;
    if (rsp_pio !== {m_tgl, m_err, 2'b00, m_nib} || rsp_pio[6] !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: got %h, expected %h", rsp_pio, {m_tgl, m_err, 2'b00, m_nib});
    end
  endtask

  task automatic test_reserved();
    int lat, vcyc, bb;
    send_cmd(3'd7, 4'h9, lat, vcyc, bb);
    model_cmd(3'd7, 4'h9, 1'b1);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL rsvd_lat: got %0d, expected 4", lat);
    end
    checks++;
    if (rsp_pio !== {m_tgl, m_err, 2'b00, m_nib} || rsp_pio[6] !== 1'b1) begin
      errors++;
      $display("FAIL rsvd_rsp: got %h, expected %h", rsp_pio, {m_tgl, m_err, 2'b00, m_nib});
    end
    send_cmd(3'd6, 4'h0, lat, vcyc, bb);
    model_cmd(3'd6, 4'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int n, trans, lat, vcyc, bb;
    logic prev;
    logic [W-1:0] g, e;
    wr_lat = 5; wr_hang = 0;
    prev = rsp_pio[7];
    m_tgl = ~m_tgl;
    cmd_pio = {m_tgl, 3'd3, 4'h0};
    model_cmd(3'd3, 4'h0, 1'b1);
    n = 0;
    while (bus_wr_valid !== 1'b1 && n < 50) begin @(negedge clk_clk); n++; end
    checks++;
    if (bus_wr_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wait: got valid %b, expected 1", bus_wr_valid);
    end
    m_tgl = ~m_tgl;
    cmd_pio = {m_tgl, 3'd2, 4'h7};
    model_cmd(3'd2, 4'h7, 1'b1);
    trans = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_clk);
      if (rsp_pio[7] !== prev) trans++;
      prev = rsp_pio[7];
    end
    checks++;
    if (trans != 2) begin
      errors++;
      $display("FAIL b2b_acks: got %0d ack toggles, expected 2", trans);
    end
    checks++;
    if (rsp_pio !== {m_tgl, m_err, 2'b00, m_nib}) begin
      errors++;
      $display("FAIL b2b_rsp: got %h, expected %h", rsp_pio, {m_tgl, m_err, 2'b00, m_nib});
    end
    wr_lat = 0;
    send_cmd(3'd3, 4'h0, lat, vcyc, bb);
    model_cmd(3'd3, 4'h0, 1'b1);
    checks++;
    if (vcyc != 1) begin
      errors++;
      $display("FAIL b2b_fastwr: got %0d valid cycles, expected 1", vcyc);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_data: got %h, expected %h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int lat, vcyc, bb, exp_lat;
    logic [2:0] op;
    logic [3:0] nib;
    logic [W-1:0] g, e;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      nib = 4'($urandom_range(0, 15));
      wr_lat = $urandom_range(0, 4);
      rd_lat = $urandom_range(1, 3);
      rd_val = 16'($urandom);
      send_cmd(op, nib, lat, vcyc, bb);
      model_cmd(op, nib, 1'b1);
      exp_lat = (op == 3'd3) ? 4 + wr_lat + 1 : (op == 3'd4) ? 4 + rd_lat : 4;
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL rnd_lat[%0d] op%0d: got %0d, expected %0d", i, op, lat, exp_lat);
      end
      checks++;
      if (rsp_pio !== {m_tgl, m_err, 2'b00, m_nib}) begin
        errors++;
        $display("FAIL rnd_rsp[%0d] op%0d: got %h, expected %h", i, op, rsp_pio, {m_tgl, m_err, 2'b00, m_nib});
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rnd_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rnd_data: got %h, expected %h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int n, lat, vcyc, bb;
    logic [W-1:0] g;
    wr_hang = 1;
    m_tgl = ~m_tgl;
    cmd_pio = {m_tgl, 3'd3, 4'h0};
    n = 0;
    while (bus_wr_valid !== 1'b1 && n < 50) begin @(negedge clk_clk); n++; end
    checks++;
    if (bus_wr_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_wait: got valid %b, expected 1", bus_wr_valid);
    end
    #2;
    reset_reset_n = 1'b0;
    cmd_pio = 8'h00; cmd8 = 8'h00;
    #1;
    checks++;
    if (bus_wr_valid !== 1'b0 || rsp_pio !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid: got valid %b rsp %h, expected 0 00", bus_wr_valid, rsp_pio);
    end
    wr_hang = 0; wr_lat = 1;
    model_reset();
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    send_cmd(3'd1, 4'h3, lat, vcyc, bb); model_cmd(3'd1, 4'h3, 1'b1);
    send_cmd(3'd2, 4'h9, lat, vcyc, bb); model_cmd(3'd2, 4'h9, 1'b1);
    send_cmd(3'd3, 4'h0, lat, vcyc, bb); model_cmd(3'd3, 4'h0, 1'b1);
    checks++;
    if (rsp_pio !== {m_tgl, m_err, 2'b00, m_nib}) begin
      errors++;
      $display("FAIL rst_after_rsp: got %h, expected %h", rsp_pio, {m_tgl, m_err, 2'b00, m_nib});
    end
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL rst_after_count: got %0d writes, expected 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      checks++;
      if (g !== 20'h30009) begin
        errors++;
        $display("FAIL rst_after_data: got %h, expected 30009", g);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_seq();
    test_read_seq();
    test_narrow();
    test_timeout();
    test_reserved();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
